// File: rtl/elgamal_pkg.sv
//------------------------------------------------------------------------------
// Module   : elgamal_pkg
// Brief    : Shared FSM states, LFSR seed and tap selection for the ElGamal engines.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package elgamal_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REDUCE     = 3'd1,
    KEYGEN     = 3'd2,
    EXP_START  = 3'd3,
    EXP_WAIT   = 3'd4,
    EXP_UPDATE = 3'd5,
    OUTPUT     = 3'd6
  } state_t;

  // Low byte is non-zero so truncated seeds stay valid for small widths.
  localparam logic [63:0] c_lfsr_seed = 64'h9E37_79B9_7F4A_7C15;

  // Right-shifting Galois masks; bit size-1 is always set, which keeps the map invertible.
  function automatic logic [63:0] lfsr_taps(input int unsigned size);
    logic [63:0] taps;
    case (size)
      8:       taps = 64'h0000_0000_0000_00B8;
      16:      taps = 64'h0000_0000_0000_B400;
      24:      taps = 64'h0000_0000_00E1_0000;
      32:      taps = 64'h0000_0000_8020_0003;
      64:      taps = 64'hD800_0000_0000_0000;
      default: taps = (64'd1 << (size - 1)) | 64'd1;
    endcase
    return taps;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_mul.sv
//------------------------------------------------------------------------------
// Module   : mod_mul
// Brief    : Interleaved MSB-first modular multiplier, one bit of b per cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mod_mul #(
  parameter int unsigned SIZE = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic [SIZE-1:0] p,
  output logic            done,
  output logic [SIZE-1:0] result
);

  localparam int unsigned CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] c_last = CW'(SIZE - 1);

  logic [SIZE-1:0] r_a;
  logic [SIZE-1:0] r_b;
  logic [SIZE-1:0] r_p;
  logic [SIZE-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;

  logic [SIZE:0]   w_dbl;
  logic [SIZE:0]   w_red1;
  logic [SIZE:0]   w_sum;
  logic [SIZE-1:0] w_red2;

  // Operands are below p, so every intermediate fits in SIZE+1 bits.
  always_comb begin
    w_dbl  = {r_acc, 1'b0};
    w_red1 = (w_dbl >= {1'b0, r_p}) ? (w_dbl - {1'b0, r_p}) : w_dbl;
    w_sum  = r_b[SIZE-1] ? (w_red1 + {1'b0, r_a}) : w_red1;
    w_red2 = (w_sum >= {1'b0, r_p}) ? SIZE'(w_sum - {1'b0, r_p}) : w_sum[SIZE-1:0];
  end

  assign done   = r_busy && (r_cnt == c_last);
  assign result = r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_p    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_a    <= a;
      r_b    <= b;
      r_p    <= p;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_acc <= w_red2;
      r_b   <= r_b << 1;
      r_cnt <= r_cnt + CW'(1);
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/encrypting_entity.sv
//------------------------------------------------------------------------------
// Module   : encrypting_entity
// Brief    : ElGamal encryptor: gamma = alpha^k mod p, delta = m*beta^k mod p, constant time.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module encrypting_entity
  import elgamal_pkg::*;
#(
  parameter int unsigned     SIZE    = 64,
  parameter logic [SIZE-1:0] FIXED_K = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] input_first_tdata,
  input  logic            input_first_tvalid,
  output logic            input_first_tready,
  input  logic [SIZE-1:0] input_second_tdata,
  input  logic            input_second_tvalid,
  output logic            input_second_tready,
  input  logic [SIZE-1:0] input_third_tdata,
  input  logic            input_third_tvalid,
  output logic            input_third_tready,
  input  logic [SIZE-1:0] input_fourth_tdata,
  input  logic            input_fourth_tvalid,
  output logic            input_fourth_tready,
  output logic [SIZE-1:0] output_a_tdata,
  output logic            output_a_tvalid,
  input  logic            output_a_tready,
  output logic [SIZE-1:0] output_b_tdata,
  output logic            output_b_tvalid,
  input  logic            output_b_tready
);

  localparam int unsigned     BW     = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [BW-1:0]   c_last = BW'(SIZE - 1);
  localparam logic [SIZE-1:0] c_taps = SIZE'(lfsr_taps(SIZE));
  localparam logic [SIZE-1:0] c_seed = SIZE'(c_lfsr_seed);

  state_t          r_state;
  state_t          w_next;
  logic            r_in_rdy;

  logic [SIZE-1:0] r_p;
  logic [SIZE-1:0] r_rg;
  logic [SIZE-1:0] r_bg;
  logic [SIZE-1:0] r_rd;
  logic [SIZE-1:0] r_bd;
  logic [SIZE-1:0] r_k;
  logic [BW-1:0]   r_bit;
  logic [SIZE-1:0] r_lfsr;
  logic            r_oa_v;
  logic            r_ob_v;
  logic [SIZE-1:0] r_oa_d;
  logic [SIZE-1:0] r_ob_d;

  logic            w_capture;
  logic            w_k_ok;
  logic [SIZE-1:0] w_k_src;
  logic [SIZE-1:0] w_lfsr_nxt;
  logic            w_a_clear;
  logic            w_b_clear;
  logic            w_mul_start;
  logic            w_mul_done;
  logic [3:0]      w_done;
  logic [SIZE-1:0] w_mul_a [4];
  logic [SIZE-1:0] w_mul_b [4];
  logic [SIZE-1:0] w_prod  [4];

  assign input_first_tready  = r_in_rdy;
  assign input_second_tready = r_in_rdy;
  assign input_third_tready  = r_in_rdy;
  assign input_fourth_tready = r_in_rdy;
  assign output_a_tdata      = r_oa_d;
  assign output_a_tvalid     = r_oa_v;
  assign output_b_tdata      = r_ob_d;
  assign output_b_tvalid     = r_ob_v;

  assign w_capture = (r_state == IDLE) && r_in_rdy &&
                     input_first_tvalid && input_second_tvalid &&
                     input_third_tvalid && input_fourth_tvalid;

  // p has its top bit set, so p-2 cannot underflow.
  assign w_k_ok  = (FIXED_K != '0) || (r_lfsr <= (r_p - SIZE'(2)));
  assign w_k_src = (FIXED_K != '0) ? FIXED_K : r_lfsr;

  assign w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_taps) : (r_lfsr >> 1);

  assign w_a_clear = !r_oa_v || output_a_tready;
  assign w_b_clear = !r_ob_v || output_b_tready;

  assign w_mul_start = (r_state == EXP_START);
  assign w_mul_done  = &w_done;

  assign w_mul_a[0] = r_rg;  assign w_mul_b[0] = r_bg;
  assign w_mul_a[1] = r_bg;  assign w_mul_b[1] = r_bg;
  assign w_mul_a[2] = r_rd;  assign w_mul_b[2] = r_bd;
  assign w_mul_a[3] = r_bd;  assign w_mul_b[3] = r_bd;

  for (genvar g = 0; g < 4; g++) begin : g_mul
    mod_mul #(.SIZE(SIZE)) u_mod_mul (
      .clk    (clk),
      .rst    (rst),
      .start  (w_mul_start),
      .a      (w_mul_a[g]),
      .b      (w_mul_b[g]),
      .p      (r_p),
      .done   (w_done[g]),
      .result (w_prod[g])
    );
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (w_capture) w_next = REDUCE;
      REDUCE:     w_next = KEYGEN;
      KEYGEN:     if (w_k_ok) w_next = EXP_START;
      EXP_START:  w_next = EXP_WAIT;
      EXP_WAIT:   if (w_mul_done) w_next = EXP_UPDATE;
      EXP_UPDATE: w_next = (r_bit == c_last) ? OUTPUT : EXP_START;
      OUTPUT:     if (w_a_clear && w_b_clear) w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_in_rdy <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_in_rdy <= (w_next == IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= c_seed;
      r_p    <= '0;
      r_rg   <= '0;
      r_bg   <= '0;
      r_rd   <= '0;
      r_bd   <= '0;
      r_k    <= '0;
      r_bit  <= '0;
      r_oa_v <= 1'b0;
      r_ob_v <= 1'b0;
      r_oa_d <= '0;
      r_ob_d <= '0;
    end else begin
      r_lfsr <= w_lfsr_nxt;
      case (r_state)
        IDLE: begin
          if (w_capture) begin
            r_p  <= input_first_tdata;
            r_bg <= input_second_tdata;
            r_bd <= input_third_tdata;
            r_rd <= input_fourth_tdata;
          end
        end
        REDUCE: begin
          if (r_bg >= r_p) r_bg <= r_bg - r_p;
          if (r_bd >= r_p) r_bd <= r_bd - r_p;
          if (r_rd >= r_p) r_rd <= r_rd - r_p;
        end
        KEYGEN: begin
          if (w_k_ok) begin
            r_k   <= w_k_src;
            r_rg  <= SIZE'(1);
            r_bit <= '0;
          end
        end
        EXP_UPDATE: begin
          r_bg <= w_prod[1];
          r_bd <= w_prod[3];
          if (r_k[0]) begin
            r_rg <= w_prod[0];
            r_rd <= w_prod[2];
          end
          r_k   <= r_k >> 1;
          r_bit <= r_bit + BW'(1);
          if (r_bit == c_last) begin
            r_oa_v <= 1'b1;
            r_ob_v <= 1'b1;
            r_oa_d <= r_k[0] ? w_prod[0] : r_rg;
            r_ob_d <= r_k[0] ? w_prod[2] : r_rd;
          end
        end
        OUTPUT: begin
          if (output_a_tready) r_oa_v <= 1'b0;
          if (output_b_tready) r_ob_v <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_encrypting_entity.sv
//------------------------------------------------------------------------------
// Module   : tb_encrypting_entity
// Brief    : Directed vector bench for encrypting_entity (8-bit fixed-k, LFSR and 64-bit).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_encrypting_entity;

  localparam int N8 = 4;
  localparam int KS [N8] = '{1, 2, 250, 0};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] p8, a8, b8, m8;
  logic       v_p, v_a, v_b, v_m;
  logic       rdy_a, rdy_b;
  logic       rp [N8];
  logic       ra [N8];
  logic       rb [N8];
  logic       rm [N8];
  logic [7:0] ga_d [N8];
  logic       ga_v [N8];
  logic [7:0] gb_d [N8];
  logic       gb_v [N8];

  for (genvar g = 0; g < N8; g++) begin : g_dut8
    encrypting_entity #(.SIZE(8), .FIXED_K(8'(KS[g]))) u_dut (
      .clk                 (clk),
      .rst                 (rst),
      .input_first_tdata   (p8),
      .input_first_tvalid  (v_p),
      .input_first_tready  (rp[g]),
      .input_second_tdata  (a8),
      .input_second_tvalid (v_a),
      .input_second_tready (ra[g]),
      .input_third_tdata   (b8),
      .input_third_tvalid  (v_b),
      .input_third_tready  (rb[g]),
      .input_fourth_tdata  (m8),
      .input_fourth_tvalid (v_m),
      .input_fourth_tready (rm[g]),
      .output_a_tdata      (ga_d[g]),
      .output_a_tvalid     (ga_v[g]),
      .output_a_tready     (rdy_a),
      .output_b_tdata      (gb_d[g]),
      .output_b_tvalid     (gb_v[g]),
      .output_b_tready     (rdy_b)
    );
  end

  logic [63:0] p64, a64, b64, m64, g64d, d64d;
  logic        v64, o64_rdy, r64p, r64a, r64b, r64m, g64v, d64v;

  encrypting_entity #(.SIZE(64), .FIXED_K(64'd1)) u_dut64 (
    .clk                 (clk),
    .rst                 (rst),
    .input_first_tdata   (p64),
    .input_first_tvalid  (v64),
    .input_first_tready  (r64p),
    .input_second_tdata  (a64),
    .input_second_tvalid (v64),
    .input_second_tready (r64a),
    .input_third_tdata   (b64),
    .input_third_tvalid  (v64),
    .input_third_tready  (r64b),
    .input_fourth_tdata  (m64),
    .input_fourth_tvalid (v64),
    .input_fourth_tready (r64m),
    .output_a_tdata      (g64d),
    .output_a_tvalid     (g64v),
    .output_a_tready     (o64_rdy),
    .output_b_tdata      (d64d),
    .output_b_tvalid     (d64v),
    .output_b_tready     (o64_rdy)
  );

  // Expected gamma/delta for k = 1, 2, 250 in that order.
  typedef struct {
    logic [7:0]      p, a, b, m;
    logic [0:2][7:0] g;
    logic [0:2][7:0] d;
  } vec_t;

  vec_t vecs [5];
  int   checks;
  int   failures;
  logic [7:0] res_g [N8];
  logic [7:0] res_d [N8];
  int         lat   [N8];
  bit         seen  [N8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic bit all_rdy();
    bit r = 1'b1;
    for (int i = 0; i < N8; i++) r = r && rp[i] && ra[i] && rb[i] && rm[i];
    return r;
  endfunction

  // Does some k in [0, p-2] explain both ciphertext halves?
  function automatic bit k_exists(input int p, input int a, input int b, input int m,
                                  input int g, input int d);
    int ga = 1;
    int gd = m % p;
    for (int k = 0; k <= p - 2; k++) begin
      if (ga == g && gd == d) return 1'b1;
      ga = (ga * (a % p)) % p;
      gd = (gd * (b % p)) % p;
    end
    return 1'b0;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!all_rdy() && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 64'(all_rdy()), 64'd1);
  endtask

  task automatic start8(input logic [7:0] p, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] m);
    wait_idle();
    p8 = p; a8 = a; b8 = b; m8 = m;
    v_p = 1'b1; v_a = 1'b1; v_b = 1'b1; v_m = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v_p = 1'b0; v_a = 1'b0; v_b = 1'b0; v_m = 1'b0;
    chk("busy_tready_low", 64'(rp[0]), 64'd0);
  endtask

  task automatic collect8();
    int  cyc = 0;
    bit  done_all = 1'b0;
    for (int i = 0; i < N8; i++) seen[i] = 1'b0;
    while (!done_all && cyc < 3000) begin
      for (int i = 0; i < N8; i++) begin
        if (!seen[i] && ga_v[i]) begin
          seen[i]  = 1'b1;
          lat[i]   = cyc;
          res_g[i] = ga_d[i];
          res_d[i] = gb_v[i] ? gb_d[i] : 8'hxx;
        end
      end
      done_all = seen[0] && seen[1] && seen[2] && seen[3];
      if (!done_all) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("all_outputs_seen", 64'(done_all), 64'd1);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    v_p = 1'b0; v_a = 1'b0; v_b = 1'b0; v_m = 1'b0;
    rdy_a = 1'b1; rdy_b = 1'b1;
    p8 = '0; a8 = '0; b8 = '0; m8 = '0;
    v64 = 1'b0; o64_rdy = 1'b1; p64 = '0; a64 = '0; b64 = '0; m64 = '0;

    vecs[0] = '{8'd251, 8'd6,   8'd10,  8'd30,  {8'd6,   8'd36, 8'd1}, {8'd49,  8'd239, 8'd30}};
    vecs[1] = '{8'd251, 8'd255, 8'd253, 8'd0,   {8'd4,   8'd16, 8'd1}, {8'd0,   8'd0,   8'd0}};
    vecs[2] = '{8'd251, 8'd2,   8'd3,   8'd250, {8'd2,   8'd4,  8'd1}, {8'd248, 8'd242, 8'd250}};
    vecs[3] = '{8'd131, 8'd130, 8'd130, 8'd7,   {8'd130, 8'd1,  8'd1}, {8'd124, 8'd7,   8'd7}};
    vecs[4] = '{8'd255, 8'd255, 8'd254, 8'd3,   {8'd0,   8'd0,  8'd0}, {8'd252, 8'd3,   8'd3}};

    repeat (3) @(negedge clk);
    chk("rst_in_tready",   64'(rp[0]),   64'd0);
    chk("rst_a_tvalid",    64'(ga_v[0]), 64'd0);
    chk("rst_b_tvalid",    64'(gb_v[0]), 64'd0);
    chk("rst_a_tdata",     64'(ga_d[0]), 64'd0);
    chk("rst64_in_tready", 64'(r64p),    64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tready", 64'(rp[0]), 64'd1);

    for (int vi = 0; vi < 5; vi++) begin
      start8(vecs[vi].p, vecs[vi].a, vecs[vi].b, vecs[vi].m);
      collect8();
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("v%0d_k%0d_gamma", vi, KS[i]), 64'(res_g[i]), 64'(vecs[vi].g[i]));
        chk($sformatf("v%0d_k%0d_delta", vi, KS[i]), 64'(res_d[i]), 64'(vecs[vi].d[i]));
        chk($sformatf("v%0d_k%0d_latency", vi, KS[i]), 64'(lat[i]), 64'd82);
      end
      chk($sformatf("v%0d_lfsr_min_latency", vi), 64'(lat[3] >= 82), 64'd1);
      chk($sformatf("v%0d_lfsr_consistent", vi),
          64'(k_exists(int'(vecs[vi].p), int'(vecs[vi].a), int'(vecs[vi].b), int'(vecs[vi].m),
                       int'(res_g[3]), int'(res_d[3]))), 64'd1);
    end

    // Alpha valid held low: nothing captured.
    wait_idle();
    p8 = 8'd251; a8 = 8'd255; b8 = 8'd253; m8 = 8'd0;
    v_p = 1'b1; v_b = 1'b1; v_m = 1'b1; v_a = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("partial_tready_c%0d", c), 64'(rp[0]), 64'd1);
    end
    v_p = 1'b0; v_b = 1'b0; v_m = 1'b0;
    repeat (90) @(negedge clk);
    chk("partial_no_output", 64'(ga_v[0]), 64'd0);

    // Output backpressure on delta.
    rdy_b = 1'b0;
    start8(vecs[0].p, vecs[0].a, vecs[0].b, vecs[0].m);
    begin
      int n = 0;
      while (!ga_v[0] && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("bp_a_valid_seen", 64'(ga_v[0]), 64'd1);
    end
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp_a_dropped_c%0d", c), 64'(ga_v[0]), 64'd0);
      chk($sformatf("bp_b_held_c%0d", c),    64'(gb_v[0]), 64'd1);
      chk($sformatf("bp_b_data_c%0d", c),    64'(gb_d[0]), 64'd49);
      chk($sformatf("bp_in_busy_c%0d", c),   64'(rp[0]),   64'd0);
      @(negedge clk);
    end
    rdy_b = 1'b1;
    @(negedge clk);
    chk("bp_b_dropped", 64'(gb_v[0]), 64'd0);
    chk("bp_idle_after_b", 64'(rp[0]), 64'd1);

    // Reset in the middle of exponentiation.
    start8(vecs[0].p, vecs[0].a, vecs[0].b, vecs[0].m);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_a_tvalid", 64'(ga_v[0]), 64'd0);
    chk("midrst_b_tvalid", 64'(gb_v[0]), 64'd0);
    chk("midrst_a_tdata",  64'(ga_d[0]), 64'd0);
    chk("midrst_b_tdata",  64'(gb_d[0]), 64'd0);
    chk("midrst_tready",   64'(rp[0]),   64'd0);
    rst = 1'b0;
    start8(vecs[0].p, vecs[0].a, vecs[0].b, vecs[0].m);
    collect8();
    chk("rerun_gamma",   64'(res_g[0]), 64'd6);
    chk("rerun_delta",   64'(res_d[0]), 64'd49);
    chk("rerun_latency", 64'(lat[0]),   64'd82);

    // 64-bit operands, k = 1.
    begin
      int n = 0;
      while (!r64p && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("w64_idle", 64'(r64p), 64'd1);
      p64 = 64'd18446744073709551337;
      a64 = 64'd9223372036854775433;
      b64 = 64'd9223372036854775433;
      m64 = 64'd2;
      v64 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v64 = 1'b0;
      n = 0;
      while (!g64v && n < 6000) begin
        @(negedge clk);
        n++;
      end
      chk("w64_latency", 64'(n), 64'd4226);
      chk("w64_gamma", g64d, 64'd9223372036854775433);
      chk("w64_delta", d64d, 64'd18446744073709550866);
      chk("w64_b_valid", 64'(d64v), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/encrypting_entity.md
# encrypting_entity

ElGamal encryption engine; the transmit-side counterpart of `decrypting_entity`. It accepts the domain parameters (p, alpha), the receiver's public key beta and a plaintext block m. It emits the ciphertext pair gamma = alpha^k mod p and delta = m·beta^k mod p, where k is an internally generated ephemeral key. Runtime is constant regardless of k, to avoid a timing side channel.

## Interface
- `SIZE`, 64: operand width; p must have bit SIZE-1 set.
- `FIXED_K`, 0: if non-zero, use as k verbatim (no range check); if 0, k comes from the internal LFSR.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `input_first_tdata/tvalid/tready`  in/in/out  SIZE/1/1  modulus p.
- `input_second_tdata/tvalid/tready`  in/in/out  SIZE/1/1  generator alpha.
- `input_third_tdata/tvalid/tready`  in/in/out  SIZE/1/1  public key beta.
- `input_fourth_tdata/tvalid/tready`  in/in/out  SIZE/1/1  plaintext m.
- `output_a_tdata/tvalid/tready`  out/out/in  SIZE/1/1  gamma.
- `output_b_tdata/tvalid/tready`  out/out/in  SIZE/1/1  delta.

## Operation
- **LFSR.** A SIZE-bit maximal-length Galois LFSR with a non-zero seed free-runs every cycle from reset. It never reaches 0.
- **IDLE.** All four `input_*_tready` are high. When all four `tvalid` are high in the same cycle, all four operands are captured and the FSM goes to REDUCE. Partial valids are ignored: nothing is captured and tready stays high.
- **REDUCE** (1 cycle). Each of alpha, beta and m gets one conditional subtraction: x ≥ p → x−p. This is exact because p ≥ 2^(SIZE-1).
- **KEYGEN.**
  - FIXED_K≠0: load k, 1 cycle.
  - FIXED_K=0: sample the LFSR each cycle until the sample is ≤ p−2, then load it.
- **EXP.** Runs LSB-first square-and-multiply over all SIZE bits of k; leading zeros are not skipped.
  - Registers: rg=1, bg=alpha, rd=m, bd=beta.
  - Per bit, four mod_mul run in parallel: rg·bg, bg·bg, rd·bd, bd·bd.
  - On completion: bg, bd ← squares. If k[i]=1, rg and rd ← products; otherwise they are kept.
  - Then shift k and increment the bit counter.
- **OUTPUT.** `output_a_tvalid` and `output_b_tvalid` rise together, with tdata = rg and rd.
  - Each output drops tvalid on its own handshake (tvalid & tready). Data stays stable while tvalid is high.
  - When both have been accepted, the FSM returns to IDLE (same edge if both accept together).
- **Reset.** Outputs reset to tvalid=0, tdata=0 and input tready=0. The FSM enters IDLE on the first cycle after reset (tready=1). A reset mid-computation discards all state; no partial result is emitted.
- **Arithmetic.** mod_mul is interleaved MSB-first over SIZE cycles:
  - acc ← 2·acc; if acc ≥ p, subtract p.
  - If b bit is set: acc ← acc + a; if acc ≥ p, subtract p.
  - Intermediates are SIZE+1 bits. Operands are < p, so the result is < p.

## Timing
- Per exponent bit: 1 start cycle + SIZE multiply cycles + 1 update cycle = SIZE+2.
- FIXED_K≠0: input handshake edge → output tvalid = 2 + SIZE·(SIZE+2) cycles. That is 4226 for SIZE=64 and 82 for SIZE=8.
- LFSR mode adds one cycle per rejected sample.
- Input tready is low from the capture edge until the FSM is back in IDLE; there is no overlap between operations.
- Output tready is ignored while tvalid is low.

## Structure
- Package `elgamal_pkg`: FSM state enum (IDLE, REDUCE, KEYGEN, EXP_START, EXP_WAIT, EXP_UPDATE, OUTPUT), LFSR seed and tap constants. It is shared with decrypting_entity's key generator.
- Sub-module `mod_mul` (start, a, b, p → done, result), instantiated 4×. It is reusable by the decryptor.

## Test plan
1. SIZE=8, FIXED_K=1, p=251, alpha=6, beta=10, m=30 → gamma=6, delta=49; tvalid exactly 82 cycles after accept.
2. SIZE=8, FIXED_K=2, same operands → gamma=36, delta=239; FIXED_K=250 → gamma=1, delta=30 (Fermat).
3. SIZE=8, FIXED_K=1, alpha=255, beta=253, m=0 → gamma=4 (reduced), delta=0; with alpha valid held low, no capture and tready stays 1.
4. SIZE=64, FIXED_K=1, p=18446744073709551337, alpha=beta=9223372036854775433, m=2 → gamma=9223372036854775433, delta=18446744073709550866.
5. Backpressure: hold output_b_tready=0 for 10 cycles after output_a accepts → b data stable, a tvalid=0, inputs not ready; IDLE only after b accepts.
6. Assert rst mid-EXP → next cycle all tvalid=0, tdata=0; a following run of test 1 gives identical results.
